// File: rtl/uart_bridge_pkg.sv
// Shared command/reply codes and FSM state type for the UART register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR_W,
    GET_ADDR_R,
    GET_DATA,
    DO_WRITE,
    DO_READ,
    WAIT_RD,
    SEND
  } bridge_state_t;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// UART byte stream plus simple register bus seen by the bridge.
interface uart_reg_bridge_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 tx_rdy;
  logic                 tx_vld;
  logic [DATA_BITS-1:0] tx_data;
  logic [DATA_BITS-1:0] reg_addr;
  logic                 reg_wr_en;
  logic [DATA_BITS-1:0] reg_wr_data;
  logic                 reg_rd_en;
  logic [DATA_BITS-1:0] reg_rd_data;
  logic                 busy;
  logic                 cmd_err;
  logic                 timeout_err;
  logic                 overrun_err;

  modport slave (
    input  rx_valid, rx_data, tx_rdy, reg_rd_data,
    output tx_vld, tx_data, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
           busy, cmd_err, timeout_err, overrun_err
  );

  modport master (
    output rx_valid, rx_data, tx_rdy, reg_rd_data,
    input  tx_vld, tx_data, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
           busy, cmd_err, timeout_err, overrun_err
  );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: down-counter reloaded on each accepted byte, expires at zero.
module uart_frame_timer #(
  parameter int TIMEOUT_CLKS = 480000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_reload,
  input  logic i_enable,
  output logic o_expired
);

  localparam int               W    = $clog2(TIMEOUT_CLKS);
  localparam logic [W-1:0]     LOAD = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] r_cnt;

  // Holds at zero once expired rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= LOAD;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = i_enable && !i_reload && (r_cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-command bridge: parses 'W' addr data / 'R' addr frames from the UART
// stream, strobes the register bus and replies with ACK, NAK or read data.
//
// state      | meaning
// IDLE       | waiting for a command byte
// GET_ADDR_W | write command seen, waiting for address
// GET_ADDR_R | read command seen, waiting for address
// GET_DATA   | write address latched, waiting for data
// DO_WRITE   | write strobe cycle
// DO_READ    | read strobe cycle
// WAIT_RD    | capture read data into reply
// SEND       | reply byte offered until accepted
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int TIMEOUT_CLKS = 480000
) (
  input logic              clk,
  input logic              reset,
  uart_reg_bridge_if.slave bus
);

  localparam logic [DATA_BITS-1:0] C_WR  = DATA_BITS'(CMD_WR);
  localparam logic [DATA_BITS-1:0] C_RD  = DATA_BITS'(CMD_RD);
  localparam logic [DATA_BITS-1:0] C_ACK = DATA_BITS'(ACK);
  localparam logic [DATA_BITS-1:0] C_NAK = DATA_BITS'(NAK);

  bridge_state_t        r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_nxt;
  logic [DATA_BITS-1:0] r_addr, r_wr_data;
  logic                 r_cmd_err, r_timeout_err, r_overrun_err;
  logic                 w_in_frame, w_accept, w_overrun, w_expired;
  logic                 w_cmd_err, w_timeout;

  assign w_in_frame = (r_state == GET_ADDR_W) || (r_state == GET_ADDR_R) ||
                      (r_state == GET_DATA);
  assign w_accept   = bus.rx_valid && ((r_state == IDLE) || w_in_frame);
  assign w_overrun  = bus.rx_valid && !((r_state == IDLE) || w_in_frame);

  uart_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_reload (w_accept),
    .i_enable (w_in_frame),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx_data;
    w_cmd_err   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == C_WR) begin
            w_state_nxt = GET_ADDR_W;
          end else if (bus.rx_data == C_RD) begin
            w_state_nxt = GET_ADDR_R;
          end else begin
            w_state_nxt = SEND;
            w_tx_nxt    = C_NAK;
            w_cmd_err   = 1'b1;
          end
        end
      end
      GET_ADDR_W, GET_ADDR_R, GET_DATA: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (bus.rx_valid) begin
          if (r_state == GET_ADDR_W)      w_state_nxt = GET_DATA;
          else if (r_state == GET_ADDR_R) w_state_nxt = DO_READ;
          else                            w_state_nxt = DO_WRITE;
        end else if (w_expired) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      DO_WRITE: begin
        w_state_nxt = SEND;
        w_tx_nxt    = C_ACK;
      end
      DO_READ: w_state_nxt = WAIT_RD;
      WAIT_RD: begin
        w_state_nxt = SEND;
        w_tx_nxt    = bus.reg_rd_data;
      end
      SEND: if (bus.tx_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tx_data     <= '0;
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_cmd_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_data     <= w_tx_nxt;
      if (w_accept && ((r_state == GET_ADDR_W) || (r_state == GET_ADDR_R)))
        r_addr <= bus.rx_data;
      if (w_accept && (r_state == GET_DATA))
        r_wr_data <= bus.rx_data;
      r_cmd_err     <= w_cmd_err;
      r_timeout_err <= w_timeout;
      r_overrun_err <= w_overrun;
    end
  end

  assign bus.tx_vld      = (r_state == SEND);
  assign bus.tx_data     = r_tx_data;
  assign bus.reg_addr    = r_addr;
  assign bus.reg_wr_en   = (r_state == DO_WRITE);
  assign bus.reg_wr_data = r_wr_data;
  assign bus.reg_rd_en   = (r_state == DO_READ);
  assign bus.busy        = (r_state != IDLE);
  assign bus.cmd_err     = r_cmd_err;
  assign bus.timeout_err = r_timeout_err;
  assign bus.overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: directed frames followed by random
// frames, gaps, timeouts, overruns and TX backpressure.
module tb_uart_reg_bridge;
  import uart_bridge_pkg::*;

  localparam int DB = 8;
  localparam int T  = 16;
  localparam int K_CMD = 0, K_TO = 1, K_OVR = 2;

  typedef struct { logic [7:0] data; int cyc; } tx_exp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  typedef struct { logic [7:0] addr; int cyc; } rd_exp_t;
  typedef struct { int kind; int cyc; } err_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  tx_exp_t  q_tx[$];
  wr_exp_t  q_wr[$];
  rd_exp_t  q_rd[$];
  err_exp_t q_err[$];
  logic [7:0] ref_regs [256];
  logic [7:0] mem [256];

  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;
  logic rd_due = 1'b0;
  logic [7:0] rd_due_addr = 8'h00;

  uart_reg_bridge_if #(.DATA_BITS(DB)) bus ();

  uart_reg_bridge #(.DATA_BITS(DB), .TIMEOUT_CLKS(T)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h22) return 8'h3C;
    return 8'(i * 37 + 11);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- environment: tx_rdy driver and register slave
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.tx_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (bus.reg_wr_en === 1'b1) mem[bus.reg_addr] = bus.reg_wr_data;
      rd_due      = (bus.reg_rd_en === 1'b1);
      rd_due_addr = bus.reg_addr;
    end
  end

  initial begin
    bus.reg_rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.reg_rd_data = rd_due ? mem[rd_due_addr] : 8'($urandom);
    end
  end

  // ---------------- monitor
  logic       in_tx = 1'b0;
  logic       tx_unstable = 1'b0;
  logic [7:0] tx_first;
  int         tx_start;
  tx_exp_t    e_tx;
  wr_exp_t    e_wr;
  rd_exp_t    e_rd;
  err_exp_t   e_err;

  task automatic check_err(input string name, input int kind);
    if (q_err.size() == 0) begin
      unexpected(name, 1);
    end else begin
      e_err = q_err.pop_front();
      chk({name, "_kind"}, kind, e_err.kind);
      chk({name, "_cycle"}, cyc, e_err.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_tx = 1'b0;
    end else begin
      if (bus.tx_vld === 1'b1) begin
        if (!in_tx) begin
          in_tx       = 1'b1;
          tx_first    = bus.tx_data;
          tx_start    = cyc;
          tx_unstable = 1'b0;
        end else if (bus.tx_data !== tx_first) begin
          tx_unstable = 1'b1;
        end
        if (bus.tx_rdy === 1'b1) begin
          in_tx = 1'b0;
          if (q_tx.size() == 0) unexpected("tx_transfer", bus.tx_data);
          else begin
            e_tx = q_tx.pop_front();
            chk("tx_data", bus.tx_data, e_tx.data);
            chk("tx_start_cycle", tx_start, e_tx.cyc);
            chk("tx_data_stable", tx_unstable, 0);
          end
        end
      end
      if (bus.reg_wr_en === 1'b1) begin
        if (q_wr.size() == 0) unexpected("reg_wr_en", bus.reg_addr);
        else begin
          e_wr = q_wr.pop_front();
          chk("wr_addr", bus.reg_addr, e_wr.addr);
          chk("wr_data", bus.reg_wr_data, e_wr.data);
          chk("wr_cycle", cyc, e_wr.cyc);
        end
      end
      if (bus.reg_rd_en === 1'b1) begin
        if (q_rd.size() == 0) unexpected("reg_rd_en", bus.reg_addr);
        else begin
          e_rd = q_rd.pop_front();
          chk("rd_addr", bus.reg_addr, e_rd.addr);
          chk("rd_cycle", cyc, e_rd.cyc);
        end
      end
      if (bus.cmd_err === 1'b1)     check_err("cmd_err", K_CMD);
      if (bus.timeout_err === 1'b1) check_err("timeout_err", K_TO);
      if (bus.overrun_err === 1'b1) check_err("overrun_err", K_OVR);
    end
  end

  // ---------------- stimulus and reference model
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int g);
    repeat (g) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output int n);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = cyc;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic inject(input int last_n);
    int m;
    send_byte(8'($urandom), m);
    q_err.push_back('{K_OVR, m + 1});
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int g1,
                          input int g2, input bit inj);
    int n;
    send_byte(CMD_WR, n); idle(g1);
    send_byte(a, n);      idle(g2);
    send_byte(d, n);
    q_wr.push_back('{a, d, n + 1});
    q_tx.push_back('{ACK, n + 2});
    ref_regs[a] = d;
    if (inj) inject(n);
  endtask

  task automatic do_read(input logic [7:0] a, input int g1, input bit inj);
    int n;
    send_byte(CMD_RD, n); idle(g1);
    send_byte(a, n);
    q_rd.push_back('{a, n + 1});
    q_tx.push_back('{ref_regs[a], n + 3});
    if (inj) inject(n);
  endtask

  task automatic do_unknown(input logic [7:0] c, input bit inj);
    int n;
    send_byte(c, n);
    q_err.push_back('{K_CMD, n + 1});
    q_tx.push_back('{NAK, n + 1});
    if (inj) inject(n);
  endtask

  // Frame abandoned after 1 or 2 bytes; abort is due T+1 cycles after the last one.
  task automatic do_timeout(input bit is_wr, input bit with_addr);
    int n;
    send_byte(is_wr ? CMD_WR : CMD_RD, n);
    if (with_addr && is_wr) send_byte(8'($urandom), n);
    q_err.push_back('{K_TO, n + T + 1});
    idle(T);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk(name, bus.busy, 0);
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.tx_vld, bus.tx_data, bus.reg_addr, bus.reg_wr_en, bus.reg_wr_data,
            bus.reg_rd_en, bus.busy, bus.cmd_err, bus.timeout_err, bus.overrun_err};
  endfunction

  function automatic int pick_gap();
    int r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r < 9) return $urandom_range(0, T - 1);
    return T - 1;
  endfunction

  initial begin
    int n;
    logic [7:0] c;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < 256; i++) ref_regs[i] = init_val(i);

    reset = 1'b1;
    tick(); tick();
    chk("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    tick();
    chk("post_reset_outputs", all_outputs(), 0);

    do_write(8'h10, 8'hA5, 0, 0, 1'b0);
    wait_idle("write_busy_drops");
    do_read(8'h22, 0, 1'b0);
    wait_idle("read_busy_drops");
    do_unknown(8'h41, 1'b0);
    wait_idle("nak_busy_drops");
    do_read(8'h00, 0, 1'b0);
    wait_idle("read2_busy_drops");

    do_timeout(1'b1, 1'b0);
    wait_idle("timeout_busy_drops");
    do_read(8'h01, 0, 1'b0);
    wait_idle("read_after_timeout");

    // Byte arriving exactly on the expiry cycle is accepted.
    do_write(8'h33, 8'h44, T - 1, T - 1, 1'b0);
    wait_idle("expiry_edge_write");
    do_read(8'h33, 0, 1'b0);
    wait_idle("expiry_edge_read");

    rdy_force = 1'b0;
    do_read(8'h05, 0, 1'b0);
    idle(9);
    inject(0);
    idle(38);
    chk("bp_tx_vld_held", bus.tx_vld, 1);
    rdy_force = 1'b1;
    wait_idle("bp_busy_drops");

    send_byte(CMD_WR, n);
    send_byte(8'h10, n);
    reset = 1'b1;
    tick();
    chk("midframe_reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    idle(2);
    do_unknown(8'hA5, 1'b0);
    wait_idle("after_reset_nak");

    rdy_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int  kind = $urandom_range(0, 9);
      bit  inj  = ($urandom_range(0, 4) == 0);
      if (kind < 4) begin
        do_write(8'($urandom), 8'($urandom), pick_gap(), pick_gap(), inj);
      end else if (kind < 7) begin
        do_read(8'($urandom), pick_gap(), inj);
      end else if (kind < 9) begin
        c = 8'($urandom);
        while (c == CMD_WR || c == CMD_RD) c = 8'($urandom);
        do_unknown(c, inj);
      end else begin
        do_timeout($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      wait_idle("random_busy_drops");
      idle($urandom_range(0, 3));
    end
    rdy_rand = 1'b0;
    idle(5);

    chk("tx_queue_drained", q_tx.size(), 0);
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("rd_queue_drained", q_rd.size(), 0);
    chk("err_queue_drained", q_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
